// File: rtl/handle_allocator.sv
// Free-list allocator for handle-translation cells: hands out and reclaims handle ids and
// emits the map/valid write strobes that program each cell. The top id is reserved.
//
// state  | meaning
// INIT   | seeding the free-list with ids 0..NUM-1, clearing each cell's valid bit
// IDLE   | ready for one alloc/free request
// UPDATE | strobes for the accepted request are on the outputs
// RESP   | response held until the consumer takes it
module handle_allocator #(
  parameter int W  = 16,
  parameter int HW = 3,
  parameter int MW = 8
) (
  input  logic          i_clock,
  input  logic          i_reset_n,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_op,
  input  logic [HW-1:0] i_req_id,
  input  logic [MW-1:0] i_req_base,
  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [HW-1:0] o_rsp_id,
  output logic          o_rsp_err,
  output logic          o_map_we,
  output logic [MW-1:0] o_map_base,
  output logic          o_valid_we,
  output logic          o_valid,
  output logic [HW-1:0] o_cell_id,
  output logic [HW-1:0] o_free_count
);

  localparam int NUM = (1 << HW) - 1;
  localparam logic [HW-1:0] LAST_ID = HW'(NUM - 1);
  localparam logic [HW-1:0] RSV_ID  = HW'(NUM);
  localparam logic [HW-1:0] ONE     = HW'(1);

  if (MW > W) begin : g_width_check
    $error("mapped base width exceeds bus width");
  end

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_UPDATE, ST_RESP} state_t;

  state_t state_q, state_d;
  logic [HW-1:0] init_cnt_q, init_cnt_d;
  logic [HW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [HW-1:0] count_q, count_d;
  logic [(1<<HW)-1:0] bitmap_q, bitmap_d;
  logic          ready_q, ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [HW-1:0] rsp_id_q, rsp_id_d;
  logic          rsp_err_q, rsp_err_d;
  logic          map_we_q, map_we_d;
  logic [MW-1:0] map_base_q, map_base_d;
  logic          valid_we_q, valid_we_d;
  logic          valid_q, valid_d;
  logic [HW-1:0] cell_q, cell_d;

  logic [HW-1:0] fifo_mem [(1<<HW)];
  logic          push, pop;
  logic [HW-1:0] push_id, head_id;

  function automatic logic [HW-1:0] wrap_inc(input logic [HW-1:0] p);
    return (p == LAST_ID) ? '0 : p + ONE;
  endfunction

  assign head_id = fifo_mem[rd_ptr_q];

  // The whole request is resolved on the accept edge so strobes land in UPDATE.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    bitmap_d    = bitmap_q;
    ready_d     = ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    map_we_d    = 1'b0;
    map_base_d  = map_base_q;
    valid_we_d  = 1'b0;
    valid_d     = valid_q;
    cell_d      = cell_q;
    push        = 1'b0;
    pop         = 1'b0;
    push_id     = '0;
    case (state_q)
      ST_INIT: begin
        push       = 1'b1;
        push_id    = init_cnt_q;
        valid_we_d = 1'b1;
        valid_d    = 1'b0;
        cell_d     = init_cnt_q;
        init_cnt_d = init_cnt_q + ONE;
        if (init_cnt_q == LAST_ID) begin
          init_cnt_d = '0;
          state_d    = ST_IDLE;
          ready_d    = 1'b1;
        end
      end
      ST_IDLE: begin
        if (i_req_valid && ready_q) begin
          ready_d = 1'b0;
          state_d = ST_UPDATE;
          if (i_req_op) begin
            if (count_q == '0) begin
              rsp_id_d  = '0;
              rsp_err_d = 1'b1;
            end else begin
              pop               = 1'b1;
              bitmap_d[head_id] = 1'b1;
              map_we_d          = 1'b1;
              map_base_d        = i_req_base;
              valid_we_d        = 1'b1;
              valid_d           = 1'b1;
              cell_d            = head_id;
              rsp_id_d          = head_id;
              rsp_err_d         = 1'b0;
            end
          end else begin
            rsp_id_d = i_req_id;
            if (i_req_id == RSV_ID || !bitmap_q[i_req_id]) begin
              rsp_err_d = 1'b1;
            end else begin
              rsp_err_d          = 1'b0;
              bitmap_d[i_req_id] = 1'b0;
              push               = 1'b1;
              push_id            = i_req_id;
              valid_we_d         = 1'b1;
              valid_d            = 1'b0;
              cell_d             = i_req_id;
            end
          end
        end
      end
      ST_UPDATE: begin
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          ready_d     = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wrap_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? wrap_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push) count_d = count_q + ONE;
    else if (pop) count_d = count_q - ONE;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      bitmap_q    <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
      map_we_q    <= 1'b0;
      map_base_q  <= '0;
      valid_we_q  <= 1'b0;
      valid_q     <= 1'b0;
      cell_q      <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      bitmap_q    <= bitmap_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      map_we_q    <= map_we_d;
      map_base_q  <= map_base_d;
      valid_we_q  <= valid_we_d;
      valid_q     <= valid_d;
      cell_q      <= cell_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset_n && push) fifo_mem[wr_ptr_q] <= push_id;
  end

  assign o_req_ready  = ready_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_id     = rsp_id_q;
  assign o_rsp_err    = rsp_err_q;
  assign o_map_we     = map_we_q;
  assign o_map_base   = map_base_q;
  assign o_valid_we   = valid_we_q;
  assign o_valid      = valid_q;
  assign o_cell_id    = cell_q;
  assign o_free_count = count_q;

endmodule

// File: tb/tb_handle_allocator.sv
// Bench for handle_allocator: directed scenarios plus randomized alloc/free traffic
// checked against a queue-based free-list model.
module tb_handle_allocator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_op, rsp_ready;
  logic [2:0] req_id;
  logic [7:0] req_base;
  logic       o_req_ready, o_rsp_valid, o_rsp_err, o_map_we, o_valid_we, o_valid;
  logic [2:0] o_rsp_id, o_cell_id, o_free_count;
  logic [7:0] o_map_base;

  int vectors = 0;
  int miscompares = 0;

  handle_allocator #(.W(16), .HW(3), .MW(8)) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(o_req_ready),
    .i_req_op(req_op), .i_req_id(req_id), .i_req_base(req_base),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_id(o_rsp_id), .o_rsp_err(o_rsp_err),
    .o_map_we(o_map_we), .o_map_base(o_map_base),
    .o_valid_we(o_valid_we), .o_valid(o_valid),
    .o_cell_id(o_cell_id), .o_free_count(o_free_count)
  );

  always #5 clk = ~clk;

  // reference model: free-list as a queue, allocation state as a flag per id
  int         free_q[$];
  bit         allocated[8];
  logic [7:0] last_base;
  logic [2:0] last_cell;
  logic       exp_map_we, exp_valid_we, exp_valid, exp_err;
  logic [2:0] exp_id, exp_count;

  // values captured from the DUT during one transaction
  logic       obs_map_we, obs_valid_we, obs_valid, obs_upd_ready, obs_upd_rsp_valid;
  logic [7:0] obs_base;
  logic [2:0] obs_cell, obs_rsp_id, obs_count;
  logic       obs_rsp_valid, obs_err, obs_late_strobe, obs_unstable;
  logic       obs_post_valid, obs_post_ready;

  task automatic model_reset();
    free_q.delete();
    for (int i = 0; i < 7; i++) free_q.push_back(i);
    for (int i = 0; i < 8; i++) allocated[i] = 1'b0;
    last_base = 8'd0;
    last_cell = 3'd6;
  endtask

  task automatic model_apply(input logic op, input logic [2:0] id, input logic [7:0] base);
    exp_map_we = 1'b0; exp_valid_we = 1'b0; exp_valid = 1'b0;
    if (op) begin
      if (free_q.size() == 0) begin
        exp_err = 1'b1; exp_id = 3'd0;
      end else begin
        exp_id = 3'(free_q.pop_front());
        allocated[exp_id] = 1'b1;
        exp_err = 1'b0; exp_map_we = 1'b1; exp_valid_we = 1'b1; exp_valid = 1'b1;
        last_base = base; last_cell = exp_id;
      end
    end else begin
      exp_id = id;
      if (id >= 3'd7 || !allocated[id]) begin
        exp_err = 1'b1;
      end else begin
        exp_err = 1'b0;
        allocated[id] = 1'b0;
        free_q.push_back(int'(id));
        exp_valid_we = 1'b1; exp_valid = 1'b0; last_cell = id;
      end
    end
    exp_count = 3'(free_q.size());
  endtask

  task automatic xact(input logic op, input logic [2:0] id, input logic [7:0] base,
                      input int stall, input bit consume);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_id = id; req_base = base;
    n = 0;
    while (o_req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    vectors++;
    if (o_req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL req_ready_timeout: ready=%b required 1", o_req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0; req_op = 1'($urandom); req_id = 3'($urandom); req_base = 8'($urandom);
    obs_map_we = o_map_we; obs_base = o_map_base; obs_valid_we = o_valid_we;
    obs_valid = o_valid; obs_cell = o_cell_id; obs_upd_ready = o_req_ready;
    obs_upd_rsp_valid = o_rsp_valid;
    @(negedge clk);
    obs_rsp_valid = o_rsp_valid; obs_rsp_id = o_rsp_id; obs_err = o_rsp_err;
    obs_count = o_free_count; obs_late_strobe = o_map_we | o_valid_we;
    obs_unstable = 1'b0;
    repeat (stall) begin
      @(negedge clk);
      if ({o_rsp_valid, o_rsp_id, o_rsp_err, o_req_ready} !== {1'b1, obs_rsp_id, obs_err, 1'b0})
        obs_unstable = 1'b1;
    end
    if (consume) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      obs_post_valid = o_rsp_valid; obs_post_ready = o_req_ready;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_id = 3'd0; req_base = 8'd0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({o_req_ready, o_rsp_valid, o_map_we, o_valid_we, o_valid, o_rsp_err, o_free_count,
         o_cell_id, o_rsp_id, o_map_base} !== 20'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: ready=%b rsp_valid=%b count=%0d cell=%0d required all zero",
               o_req_ready, o_rsp_valid, o_free_count, o_cell_id);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      vectors++;
      if ({o_valid_we, o_valid, o_cell_id} !== {1'b1, 1'b0, 3'(k - 1)}) begin
        miscompares++;
        $display("FAIL init_pulse: cycle %0d vwe=%b valid=%b cell=%0d required vwe=1 valid=0 cell=%0d",
                 k, o_valid_we, o_valid, o_cell_id, k - 1);
      end
      vectors++;
      if (o_req_ready !== ((k == 7) ? 1'b1 : 1'b0)) begin
        miscompares++;
        $display("FAIL init_ready: cycle %0d ready=%b required %b", k, o_req_ready, k == 7);
      end
    end
    @(negedge clk);
    vectors++;
    if ({o_valid_we, o_req_ready, o_free_count} !== {1'b0, 1'b1, 3'd7}) begin
      miscompares++;
      $display("FAIL init_done: vwe=%b ready=%b count=%0d required 0 1 7",
               o_valid_we, o_req_ready, o_free_count);
    end
    model_reset();
  endtask

  task automatic test_alloc_single();
    model_apply(1'b1, 3'd0, 8'd5);
    xact(1'b1, 3'd0, 8'd5, 0, 1'b1);
    vectors++;
    if ({obs_map_we, obs_base, obs_valid_we, obs_valid, obs_cell} !== {1'b1, 8'd5, 1'b1, 1'b1, 3'd0}) begin
      miscompares++;
      $display("FAIL alloc_strobes: we=%b base=%0d vwe=%b valid=%b cell=%0d required 1 5 1 1 0",
               obs_map_we, obs_base, obs_valid_we, obs_valid, obs_cell);
    end
    vectors++;
    if ({obs_upd_rsp_valid, obs_upd_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL alloc_update_cycle: rsp_valid=%b ready=%b required 0 0", obs_upd_rsp_valid, obs_upd_ready);
    end
    vectors++;
    if ({obs_rsp_valid, obs_rsp_id, obs_err, obs_count, obs_late_strobe} !== {1'b1, 3'd0, 1'b0, 3'd6, 1'b0}) begin
      miscompares++;
      $display("FAIL alloc_rsp: valid=%b id=%0d err=%b count=%0d late=%b required 1 0 0 6 0",
               obs_rsp_valid, obs_rsp_id, obs_err, obs_count, obs_late_strobe);
    end
    vectors++;
    if ({obs_post_valid, obs_post_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL alloc_release: rsp_valid=%b ready=%b required 0 1", obs_post_valid, obs_post_ready);
    end
  endtask

  task automatic test_exhaust();
    logic [7:0] b;
    for (int i = 1; i <= 7; i++) begin
      b = 8'($urandom);
      model_apply(1'b1, 3'd0, b);
      xact(1'b1, 3'($urandom), b, 0, 1'b1);
      vectors++;
      if ({obs_map_we, obs_base, obs_valid_we, obs_cell} !== {exp_map_we, last_base, exp_valid_we, last_cell}) begin
        miscompares++;
        $display("FAIL exhaust_strobes: alloc %0d we=%b base=%0d vwe=%b cell=%0d required %b %0d %b %0d",
                 i, obs_map_we, obs_base, obs_valid_we, obs_cell, exp_map_we, last_base, exp_valid_we, last_cell);
      end
      vectors++;
      if ({obs_rsp_id, obs_err, obs_count} !== {exp_id, exp_err, exp_count}) begin
        miscompares++;
        $display("FAIL exhaust_rsp: alloc %0d id=%0d err=%b count=%0d required %0d %b %0d",
                 i, obs_rsp_id, obs_err, obs_count, exp_id, exp_err, exp_count);
      end
    end
  endtask

  task automatic test_free_realloc();
    model_apply(1'b0, 3'd3, 8'd0);
    xact(1'b0, 3'd3, 8'($urandom), 0, 1'b1);
    vectors++;
    if ({obs_map_we, obs_valid_we, obs_valid, obs_cell, obs_rsp_id, obs_err} !== {1'b0, 1'b1, 1'b0, 3'd3, 3'd3, 1'b0}) begin
      miscompares++;
      $display("FAIL free_id3: we=%b vwe=%b valid=%b cell=%0d id=%0d err=%b required 0 1 0 3 3 0",
               obs_map_we, obs_valid_we, obs_valid, obs_cell, obs_rsp_id, obs_err);
    end
    model_apply(1'b1, 3'd0, 8'hA5);
    xact(1'b1, 3'd0, 8'hA5, 0, 1'b1);
    vectors++;
    if ({obs_rsp_id, obs_err, obs_cell, obs_count} !== {exp_id, exp_err, last_cell, exp_count}) begin
      miscompares++;
      $display("FAIL realloc: id=%0d err=%b cell=%0d count=%0d required %0d %b %0d %0d",
               obs_rsp_id, obs_err, obs_cell, obs_count, exp_id, exp_err, last_cell, exp_count);
    end
  endtask

  task automatic test_double_free();
    model_apply(1'b0, 3'd3, 8'd0);
    xact(1'b0, 3'd3, 8'd0, 0, 1'b1);
    model_apply(1'b0, 3'd3, 8'd0);
    xact(1'b0, 3'd3, 8'd0, 0, 1'b1);
    vectors++;
    if ({obs_map_we, obs_valid_we, obs_rsp_id, obs_err, obs_count} !== {1'b0, 1'b0, 3'd3, 1'b1, exp_count}) begin
      miscompares++;
      $display("FAIL double_free: we=%b vwe=%b id=%0d err=%b count=%0d required 0 0 3 1 %0d",
               obs_map_we, obs_valid_we, obs_rsp_id, obs_err, obs_count, exp_count);
    end
    model_apply(1'b0, 3'd7, 8'd0);
    xact(1'b0, 3'd7, 8'd0, 0, 1'b1);
    vectors++;
    if ({obs_valid_we, obs_rsp_id, obs_err, obs_count} !== {1'b0, 3'd7, 1'b1, exp_count}) begin
      miscompares++;
      $display("FAIL free_reserved: vwe=%b id=%0d err=%b count=%0d required 0 7 1 %0d",
               obs_valid_we, obs_rsp_id, obs_err, obs_count, exp_count);
    end
  endtask

  task automatic test_stall_reset();
    int n;
    model_apply(1'b1, 3'd0, 8'h3C);
    xact(1'b1, 3'd0, 8'h3C, 5, 1'b0);
    vectors++;
    if ({obs_rsp_valid, obs_rsp_id, obs_err, obs_unstable} !== {1'b1, exp_id, exp_err, 1'b0}) begin
      miscompares++;
      $display("FAIL rsp_stall: valid=%b id=%0d err=%b unstable=%b required 1 %0d %b 0",
               obs_rsp_valid, obs_rsp_id, obs_err, obs_unstable, exp_id, exp_err);
    end
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({o_rsp_valid, o_req_ready, o_free_count} !== {1'b0, 1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_in_resp: rsp_valid=%b ready=%b count=%0d required 0 0 0",
               o_rsp_valid, o_req_ready, o_free_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({o_valid_we, o_valid, o_cell_id, o_req_ready} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reinit_start: vwe=%b valid=%b cell=%0d ready=%b required 1 0 0 0",
               o_valid_we, o_valid, o_cell_id, o_req_ready);
    end
    n = 0;
    while (o_req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    vectors++;
    if (n != 6) begin
      miscompares++;
      $display("FAIL reinit_length: ready after %0d more cycles required 6", n);
    end
    model_reset();
  endtask

  task automatic test_random();
    logic       op;
    logic [2:0] id;
    logic [7:0] b;
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0;
      id = 3'($urandom_range(0, 7));
      b  = 8'($urandom);
      model_apply(op, id, b);
      xact(op, id, b, $urandom_range(0, 2), 1'b1);
      vectors++;
      if ({obs_map_we, obs_base, obs_valid_we, obs_cell} !== {exp_map_we, last_base, exp_valid_we, last_cell}) begin
        miscompares++;
        $display("FAIL rand_strobes: #%0d op=%b id=%0d we=%b base=%0d vwe=%b cell=%0d required %b %0d %b %0d",
                 i, op, id, obs_map_we, obs_base, obs_valid_we, obs_cell, exp_map_we, last_base, exp_valid_we, last_cell);
      end
      if (exp_valid_we) begin
        vectors++;
        if (obs_valid !== exp_valid) begin
          miscompares++;
          $display("FAIL rand_valid_bit: #%0d valid=%b required %b", i, obs_valid, exp_valid);
        end
      end
      vectors++;
      if ({obs_rsp_valid, obs_rsp_id, obs_err, obs_count, obs_unstable, obs_late_strobe} !==
          {1'b1, exp_id, exp_err, exp_count, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL rand_rsp: #%0d op=%b valid=%b id=%0d err=%b count=%0d unstable=%b late=%b required 1 %0d %b %0d 0 0",
                 i, op, obs_rsp_valid, obs_rsp_id, obs_err, obs_count, obs_unstable, obs_late_strobe,
                 exp_id, exp_err, exp_count);
      end
      vectors++;
      if ({obs_post_valid, obs_post_ready} !== 2'b01) begin
        miscompares++;
        $display("FAIL rand_release: #%0d rsp_valid=%b ready=%b required 0 1", i, obs_post_valid, obs_post_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alloc_single();
    test_exhaust();
    test_free_realloc();
    test_double_free();
    test_stall_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
